// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage core.
// Turns load-use, memory-busy, redirect and halt events into per-stage
// write enables and flush/bubble controls. It also keeps a saturating
// stall-cycle counter and a sticky load-use protocol error flag.
module hazard_stall_ctrl #(
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   reg1_ldstall,
   input  logic                   reg2_ldstall,
   input  logic                   redirect_ex,
   input  logic                   dmem_busy,
   input  logic                   halt_wb,
   output logic                   pc_we,
   output logic                   pc_sel_redirect,
   output logic                   ifid_we,
   output logic                   ifid_flush,
   output logic                   idex_we,
   output logic                   idex_flush,
   output logic                   exmem_we,
   output logic                   exmem_bubble,
   output logic                   memwb_we,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   output logic                   err_ldstall
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_MEMWAIT = 2'd2,
      ST_HALT    = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   err_q, err_d;
   logic                   ld_use;

   assign ld_use = reg1_ldstall | reg2_ldstall;

   // Next-state and stage controls, from current state and event priority
   always_comb begin
      state_d         = state_q;
      pc_we           = 1'b0;
      pc_sel_redirect = 1'b0;
      ifid_we         = 1'b0;
      ifid_flush      = 1'b0;
      idex_we         = 1'b0;
      idex_flush      = 1'b0;
      exmem_we        = 1'b0;
      exmem_bubble    = 1'b0;
      memwb_we        = 1'b0;
      halted          = 1'b0;

      if (rst) begin
         state_d = ST_RUN;
      end else if (state_q == ST_HALT) begin
         // Frozen until reset; every input is ignored.
         halted = 1'b1;
      end else if (halt_wb) begin
         state_d = ST_HALT;
      end else if (dmem_busy) begin
         // Whole pipeline freezes while memory is busy.
         state_d = ST_MEMWAIT;
      end else if (ld_use && (state_q != ST_LDSTALL)) begin
         // Hold PC/IF/ID/EX, inject a bubble into EX/MEM. A concurrent
         // redirect is dropped: its operand is not valid yet.
         state_d      = ST_LDSTALL;
         exmem_we     = 1'b1;
         exmem_bubble = 1'b1;
         memwb_we     = 1'b1;
      end else if (redirect_ex) begin
         state_d         = ST_RUN;
         pc_we           = 1'b1;
         pc_sel_redirect = 1'b1;
         ifid_we         = 1'b1;
         ifid_flush      = 1'b1;
         idex_we         = 1'b1;
         idex_flush      = 1'b1;
         exmem_we        = 1'b1;
         memwb_we        = 1'b1;
      end else begin
         state_d  = ST_RUN;
         pc_we    = 1'b1;
         ifid_we  = 1'b1;
         idex_we  = 1'b1;
         exmem_we = 1'b1;
         memwb_we = 1'b1;
      end
   end

   // Stall counter (saturating) and sticky load-use error next values
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      err_d       = err_q;
      if (!pc_we && (state_q != ST_HALT) && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
      if ((state_q == ST_LDSTALL) && ld_use) begin
         err_d = 1'b1;
      end
   end

   // State and status registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   assign stall_cnt   = stall_cnt_q;
   assign err_ldstall = err_q;

endmodule
